// File: rtl/scaled_shift_window.sv
// scaled_shift_window
//   This block holds a window of DEPTH words, each WIDTH bits wide. On every accepted
//   input word the window shifts by one place. In the same cycle every entry is
//   transformed by op(v):
//     mode = 0 : op(v) = v * scale
//     mode = 1 : op(v) = v + scale
//   Both ops are taken modulo 2**WIDTH.
//   Once DEPTH words have been accepted, the oldest entry is presented through a
//   one-entry registered valid/ready output stage.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               synchronous clear of the window, the fill count and the output stage
//   mode, scale         op select and operand; both are sampled on accept
//   in_valid/in_ready   input handshake
//   in_data             input word
//   out_valid/out_ready output handshake
//   out_data            registered oldest-entry result
module scaled_shift_window #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             mode,
    input  logic [WIDTH-1:0] scale,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] win;
    logic [DEPTH-1:0][WIDTH-1:0] win_next;
    logic [FW-1:0]               fill;
    logic [FW-1:0]               fill_next;
    logic                        accept;

    // Result width equals WIDTH, so the product and the sum wrap modulo 2**WIDTH.
    function automatic logic [WIDTH-1:0] op(input logic [WIDTH-1:0] v,
                                            input logic m,
                                            input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        if (m) r = v + s;
        else   r = v * s;
        return r;
    endfunction

    // Ready depends only on flush and the output stage, never on in_valid.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        win_next    = win;
        win_next[0] = op(in_data, mode, scale);
        for (int i = 1; i < DEPTH; i++)
            win_next[i] = op(win[i-1], mode, scale);
        fill_next = (fill == FW'(DEPTH)) ? fill : fill + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            win       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            win  <= win_next;
            fill <= fill_next;
            if (fill_next == FW'(DEPTH)) begin
                out_valid <= 1'b1;
                out_data  <= win_next[DEPTH-1];
            end else begin
                // Still filling: input words are absorbed and no result is produced yet.
                out_valid <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
